display_output_driver: RTL and testbench
========================================

# display_output_driver

Output-side counterpart of the board input wrapper: takes the 8-digit BCD value, status bits and mode flags produced by the core and drives the DE2 seven-segment displays and red/green LEDs. Double-buffers the digits so displays change atomically on a load strobe, decodes BCD to active-low segments with optional leading-zero blanking, and runs an alarm flash sequencer on the red LEDs. Sits between the core FSM and the top-level pin assignments; all outputs are registered.

## Interface
- BLINK_DIV, 25_000_000: clkIn cycles per flash phase (0.5 s at 50 MHz); minimum 2.
- FLASH_COUNT, 5: on/off flash pairs per alarm.
- clkIn  input  1  system clock, all logic on rising edge.
- resetIn  input  1  one clock; reset is synchronous and active-high.
- digitsIn  input  32  eight BCD digits, [3:0] = digit 0 (rightmost).
- loadIn  input  1  latch digitsIn into the display buffer.
- blankLeadingIn  input  1  blank leading zeros in digits 7..1.
- statusIn  input  18  steady-state red LED pattern.
- alarmIn  input  1  single-cycle pulse starting a flash sequence.
- demoOrRealModeIn  input  1  mode flag, echoed to green LED 0.
- monitorOrMissedSceneIn  input  1  scene flag, echoed to green LED 1.
- hex0Out..hex7Out  output  7 each  active-low segments {g,f,e,d,c,b,a}.
- ledRedOut  output  18  red LEDs.
- ledGreenOut  output  8  green LEDs.

## Operation
- Digit buffer: loadIn=1 at an edge copies digitsIn into digitReg; otherwise holds. No partial updates.
- Decode per digit: 0-9 standard patterns; 10-15 show dash (7'b0111111); blank is 7'b1111111.
- Leading-zero blanking (blankLeadingIn=1): scanning from digit 7 downward, each zero digit is blanked until the first nonzero digit; digit 0 is never blanked. An invalid digit counts as nonzero.
- Prescaler: counter 0..BLINK_DIV-1, tick when it equals BLINK_DIV-1, then wraps to 0. Forced to 0 on entry to FLASH_ON from any state.
- Flash FSM states STEADY, FLASH_ON, FLASH_OFF; flashCnt counts completed pairs.
  - STEADY: ledRedOut = statusIn (registered). alarmIn -> FLASH_ON, flashCnt=0.
  - FLASH_ON: ledRedOut = all ones. tick -> FLASH_OFF.
  - FLASH_OFF: ledRedOut = all zeros. tick -> flashCnt+1; if flashCnt+1 = FLASH_COUNT -> STEADY, else FLASH_ON.
  - alarmIn in FLASH_ON/FLASH_OFF restarts: -> FLASH_ON, flashCnt=0, prescaler=0. alarmIn takes priority over a simultaneous tick.
- ledGreenOut = {5'b0, busy, monitorOrMissedSceneIn, demoOrRealModeIn}, busy = state != STEADY.
- flashCnt width = clog2(FLASH_COUNT+1); prescaler width = clog2(BLINK_DIV).

## Timing
- Reset values: all hex outputs 7'b1111111, ledRedOut 0, ledGreenOut 0, digitReg 0, state STEADY, counters 0.
- loadIn sampled at edge k -> digitReg updated at k -> hex outputs updated at edge k+1 (2-edge latency from input change).
- blankLeadingIn also acts through the output register: 1-edge latency.
- statusIn and mode flags -> LEDs: 1-edge latency.
- alarmIn sampled at edge k -> state FLASH_ON at k -> ledRedOut all ones after edge k+1; each phase lasts exactly BLINK_DIV cycles; full sequence 2*BLINK_DIV*FLASH_COUNT cycles.
- resetIn mid-flash aborts immediately to reset values; resetIn has priority over loadIn and alarmIn.

## Structure
- Package display_pkg: flash state enum, SEG_BLANK, SEG_DASH, digit pattern constants 0-9.
- Sub-module bcd_to_seven_seg: combinational 4-bit BCD + blank in -> 7-bit active-low segments, instantiated eight times.
- Top holds digit buffer, blanking chain, prescaler, flash FSM and output registers.

## Test plan
- Reset then idle: all hex = 7'h7F, ledRedOut = 0, ledGreenOut = 0.
- digitsIn=32'h0012_3456, loadIn pulse, blankLeadingIn=1: hex7/hex6 blank, hex5..hex0 show 1,2,3,4,5,6 two edges later; blankLeadingIn=0 shows zeros on hex7/hex6.
- digitsIn=32'h0000_00A0, blanking on: hex1 dash, hex0 shows 0, others blank; digitsIn=0 shows only hex0 = 0.
- BLINK_DIV=4, FLASH_COUNT=2, statusIn=18'h15555, alarmIn pulse: red all ones 4 cycles, zeros 4, ones 4, zeros 4, then 18'h15555; green bit 2 high throughout.
- Same config, second alarmIn during second FLASH_OFF: sequence restarts with full 16-cycle pattern.
- resetIn asserted during FLASH_ON with loadIn simultaneously high: next edge all outputs at reset values, digitReg = 0.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and segment constants for the display output driver
//
// Contents:
//   flashState_t  flash sequencer state encoding (STEADY, FLASH_ON, FLASH_OFF)
//   SEG_BLANK     all segments off (active-low)
//   SEG_DASH      only segment g lit, shown for non-BCD digit values
//   SEG_0..SEG_9  active-low {g,f,e,d,c,b,a} patterns for decimal digits

package display_pkg;

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flashState_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// rtl/bcd_to_seven_seg.sv - combinational BCD digit to active-low seven-segment decoder
//
// Ports:
//   bcdIn    in   4  digit value; 10..15 are shown as a dash
//   blankIn  in   1  force all segments off (overrides bcdIn)
//   segOut   out  7  active-low segments {g,f,e,d,c,b,a}

module bcd_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] bcdIn,
  input  logic       blankIn,
  output logic [6:0] segOut
);

  always_comb begin
    segOut = SEG_DASH;
    if (blankIn) begin
      segOut = SEG_BLANK;
    end else begin
      case (bcdIn)
        4'd0:    segOut = SEG_0;
        4'd1:    segOut = SEG_1;
        4'd2:    segOut = SEG_2;
        4'd3:    segOut = SEG_3;
        4'd4:    segOut = SEG_4;
        4'd5:    segOut = SEG_5;
        4'd6:    segOut = SEG_6;
        4'd7:    segOut = SEG_7;
        4'd8:    segOut = SEG_8;
        4'd9:    segOut = SEG_9;
        default: segOut = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_output_driver.sv
// rtl/display_output_driver.sv - double-buffered seven-segment and LED driver with alarm flash sequencer
//
// Parameters:
//   BLINK_DIV    clkIn cycles per flash phase (>= 2)
//   FLASH_COUNT  on/off pairs per alarm
// Ports:
//   clkIn                   in   1   system clock, rising edge
//   resetIn                 in   1   synchronous active-high reset
//   digitsIn                in   32  eight BCD digits, [3:0] = rightmost
//   loadIn                  in   1   latch digitsIn into the display buffer
//   blankLeadingIn          in   1   blank leading zeros on digits 7..1
//   statusIn                in   18  steady-state red LED pattern
//   alarmIn                 in   1   pulse that (re)starts a flash sequence
//   demoOrRealModeIn        in   1   echoed to green LED 0
//   monitorOrMissedSceneIn  in   1   echoed to green LED 1
//   hex0Out..hex7Out        out  7   active-low segments {g,f,e,d,c,b,a}
//   ledRedOut               out  18  red LEDs
//   ledGreenOut             out  8   green LEDs {5'b0, busy, scene, mode}

module display_output_driver
  import display_pkg::*;
#(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int FLASH_COUNT = 5
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [31:0] digitsIn,
  input  logic        loadIn,
  input  logic        blankLeadingIn,
  input  logic [17:0] statusIn,
  input  logic        alarmIn,
  input  logic        demoOrRealModeIn,
  input  logic        monitorOrMissedSceneIn,
  output logic [6:0]  hex0Out,
  output logic [6:0]  hex1Out,
  output logic [6:0]  hex2Out,
  output logic [6:0]  hex3Out,
  output logic [6:0]  hex4Out,
  output logic [6:0]  hex5Out,
  output logic [6:0]  hex6Out,
  output logic [6:0]  hex7Out,
  output logic [17:0] ledRedOut,
  output logic [7:0]  ledGreenOut
);

  localparam int PW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(FLASH_COUNT + 1);
  localparam logic [PW-1:0] TICK_AT  = PW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_COUNT);

  logic [31:0]   digitReg;
  logic [7:0]    blankDigit;
  logic          zeroRun;
  logic [6:0]    segNext [8];

  flashState_t   state, stateNext;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [CW-1:0] flashCnt, flashCntNext, cntInc;
  logic          tick;

  // Zeros stay blanked while every digit above them is also zero; the run
  // ends at the first nonzero (or non-BCD) digit. Digit 0 always shows.
  always_comb begin
    blankDigit = '0;
    zeroRun    = blankLeadingIn;
    for (int i = 7; i >= 1; i--) begin
      zeroRun       = zeroRun && (digitReg[4*i +: 4] == 4'd0);
      blankDigit[i] = zeroRun;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : gDecode
    bcd_to_seven_seg uDecode (
      .bcdIn   (digitReg[4*g +: 4]),
      .blankIn (blankDigit[g]),
      .segOut  (segNext[g])
    );
  end

  // Flash sequencer next state. The prescaler restarts on every alarm so
  // the first ON phase is always a full BLINK_DIV cycles; ON->OFF->ON
  // transitions land on a tick, where the counter wraps to 0 anyway.
  always_comb begin
    tick          = (prescaler == TICK_AT);
    cntInc        = flashCnt + 1'b1;
    stateNext     = state;
    flashCntNext  = flashCnt;
    prescalerNext = (alarmIn || tick) ? '0 : prescaler + 1'b1;
    if (alarmIn) begin
      stateNext    = FLASH_ON;
      flashCntNext = '0;
    end else begin
      case (state)
        FLASH_ON: begin
          if (tick) stateNext = FLASH_OFF;
        end
        FLASH_OFF: begin
          if (tick) begin
            flashCntNext = cntInc;
            stateNext    = (cntInc == CNT_LAST) ? STEADY : FLASH_ON;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state       <= STEADY;
      prescaler   <= '0;
      flashCnt    <= '0;
      digitReg    <= '0;
      hex0Out     <= SEG_BLANK;
      hex1Out     <= SEG_BLANK;
      hex2Out     <= SEG_BLANK;
      hex3Out     <= SEG_BLANK;
      hex4Out     <= SEG_BLANK;
      hex5Out     <= SEG_BLANK;
      hex6Out     <= SEG_BLANK;
      hex7Out     <= SEG_BLANK;
      ledRedOut   <= '0;
      ledGreenOut <= '0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      flashCnt  <= flashCntNext;
      if (loadIn) digitReg <= digitsIn;
      hex0Out   <= segNext[0];
      hex1Out   <= segNext[1];
      hex2Out   <= segNext[2];
      hex3Out   <= segNext[3];
      hex4Out   <= segNext[4];
      hex5Out   <= segNext[5];
      hex6Out   <= segNext[6];
      hex7Out   <= segNext[7];
      // LEDs follow the registered state, so they trail it by one edge.
      ledRedOut   <= (state == FLASH_ON)  ? '1 :
                     (state == FLASH_OFF) ? '0 : statusIn;
      ledGreenOut <= {5'b0, state != STEADY, monitorOrMissedSceneIn, demoOrRealModeIn};
    end
  end

endmodule

// File: tb/tb_display_output_driver.sv
// tb/tb_display_output_driver.sv - self-checking bench for display_output_driver

module tb_display_output_driver;

  localparam int DIV = 4;
  localparam int FC  = 2;
  localparam int SEQ = 2 * DIV * FC;
  localparam int IDLE = 1000;

  logic        clk = 1'b0;
  logic        resetIn = 1'b1;
  logic [31:0] digitsIn = '0;
  logic        loadIn = 1'b0;
  logic        blankLeadingIn = 1'b0;
  logic [17:0] statusIn = '0;
  logic        alarmIn = 1'b0;
  logic        demoOrRealModeIn = 1'b0;
  logic        monitorOrMissedSceneIn = 1'b0;
  logic [6:0]  hex0Out, hex1Out, hex2Out, hex3Out, hex4Out, hex5Out, hex6Out, hex7Out;
  logic [17:0] ledRedOut;
  logic [7:0]  ledGreenOut;
  logic [6:0]  hexArr [8];

  int checks = 0;
  int failures = 0;
  int sinceAlarm = IDLE;
  logic [31:0] mDigits = '0;

  always #5 clk = ~clk;

  display_output_driver #(.BLINK_DIV(DIV), .FLASH_COUNT(FC)) dut (
    .clkIn                  (clk),
    .resetIn                (resetIn),
    .digitsIn               (digitsIn),
    .loadIn                 (loadIn),
    .blankLeadingIn         (blankLeadingIn),
    .statusIn               (statusIn),
    .alarmIn                (alarmIn),
    .demoOrRealModeIn       (demoOrRealModeIn),
    .monitorOrMissedSceneIn (monitorOrMissedSceneIn),
    .hex0Out                (hex0Out),
    .hex1Out                (hex1Out),
    .hex2Out                (hex2Out),
    .hex3Out                (hex3Out),
    .hex4Out                (hex4Out),
    .hex5Out                (hex5Out),
    .hex6Out                (hex6Out),
    .hex7Out                (hex7Out),
    .ledRedOut              (ledRedOut),
    .ledGreenOut            (ledGreenOut)
  );

  assign hexArr[0] = hex0Out;
  assign hexArr[1] = hex1Out;
  assign hexArr[2] = hex2Out;
  assign hexArr[3] = hex3Out;
  assign hexArr[4] = hex4Out;
  assign hexArr[5] = hex5Out;
  assign hexArr[6] = hex6Out;
  assign hexArr[7] = hex7Out;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  // Digit idx is blank when blanking is on and it sits left of the most
  // significant nonzero digit (position 0 if all digits are zero).
  function automatic logic [6:0] expHex(input logic [31:0] digits, input logic blank, input int idx);
    int top = 0;
    for (int i = 0; i < 8; i++) if (digits[4*i +: 4] != 4'd0) top = i;
    if (blank && idx > top) return 7'h7F;
    return segOf(digits[4*idx +: 4]);
  endfunction

  // One clock: randomise the steady LED inputs, predict every output after
  // the edge from the inputs as they stand now, then compare.
  task automatic step();
    logic [6:0]  expSeg [8];
    logic [17:0] expRed;
    logic [7:0]  expGreen;
    logic        busy;
    int          nAfter;
    statusIn               = 18'($urandom);
    demoOrRealModeIn       = 1'($urandom);
    monitorOrMissedSceneIn = 1'($urandom);
    nAfter = sinceAlarm + 1;
    if (resetIn) begin
      expRed     = '0;
      expGreen   = '0;
      sinceAlarm = IDLE;
      for (int i = 0; i < 8; i++) expSeg[i] = 7'h7F;
      mDigits    = '0;
    end else begin
      busy     = (nAfter >= 1) && (nAfter <= SEQ);
      expRed   = !busy ? statusIn : ((((nAfter - 1) / DIV) % 2) == 0) ? 18'h3FFFF : 18'h0;
      expGreen = {5'b0, busy, monitorOrMissedSceneIn, demoOrRealModeIn};
      sinceAlarm = alarmIn ? 0 : ((nAfter > IDLE) ? IDLE : nAfter);
      for (int i = 0; i < 8; i++) expSeg[i] = expHex(mDigits, blankLeadingIn, i);
      if (loadIn) mDigits = digitsIn;
    end
    @(posedge clk);
    #1;
    checks++;
    if (ledRedOut !== expRed) begin
      failures++;
      $display("FAIL ledRedOut t=%0t got=%h exp=%h", $time, ledRedOut, expRed);
    end
    checks++;
    if (ledGreenOut !== expGreen) begin
      failures++;
      $display("FAIL ledGreenOut t=%0t got=%h exp=%h", $time, ledGreenOut, expGreen);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hexArr[i] !== expSeg[i]) begin
        failures++;
        $display("FAIL hex%0d t=%0t got=%h exp=%h", i, $time, hexArr[i], expSeg[i]);
      end
    end
  endtask

  task automatic test_reset();
    resetIn = 1'b1;
    step();
    step();
    resetIn = 1'b0;
    step();
  endtask

  task automatic loadAndCheck(input logic [31:0] d, input logic b);
    digitsIn       = d;
    blankLeadingIn = b;
    loadIn         = 1'b1;
    step();
    loadIn   = 1'b0;
    digitsIn = $urandom;
    step();
    step();
    blankLeadingIn = !b;
    step();
    step();
  endtask

  task automatic test_digits();
    loadAndCheck(32'h0012_3456, 1'b1);
    loadAndCheck(32'h0000_00A0, 1'b1);
    loadAndCheck(32'h0000_0000, 1'b1);
    loadAndCheck(32'h89AB_CDEF, 1'b0);
    for (int k = 0; k < 12; k++) begin
      logic [31:0] d;
      d = $urandom;
      // Push a random number of leading digits to zero to exercise blanking.
      d = d & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 8)));
      loadAndCheck(d, 1'($urandom));
    end
  endtask

  task automatic test_flash();
    alarmIn = 1'b1;
    step();
    alarmIn = 1'b0;
    repeat (SEQ + 4) step();
  endtask

  task automatic test_restart();
    int r;
    r = $urandom_range(0, DIV - 1);
    alarmIn = 1'b1;
    step();
    alarmIn = 1'b0;
    repeat (3 * DIV + r) step();
    alarmIn = 1'b1;
    step();
    alarmIn = 1'b0;
    repeat (SEQ + 4) step();
  endtask

  task automatic test_reset_midflash();
    loadAndCheck(32'h1234_5678, 1'b0);
    alarmIn = 1'b1;
    step();
    alarmIn = 1'b0;
    step();
    step();
    resetIn  = 1'b1;
    loadIn   = 1'b1;
    digitsIn = $urandom | 32'h1;
    step();
    resetIn        = 1'b0;
    loadIn         = 1'b0;
    blankLeadingIn = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 120; k++) begin
      alarmIn        = ($urandom_range(0, 19) == 0);
      loadIn         = ($urandom_range(0, 3) == 0);
      digitsIn       = $urandom;
      blankLeadingIn = 1'($urandom);
      step();
    end
    alarmIn = 1'b0;
    loadIn  = 1'b0;
    repeat (SEQ + 2) step();
  endtask

  initial begin
    test_reset();
    test_digits();
    test_flash();
    test_restart();
    test_reset_midflash();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
